ddram_responder: RTL

Synthesizable responder for the DDRAM burst port: it sits on the memory side of the 64-bit DDRAM_* interface driven by the channel arbiter and answers its read and write commands from on-chip block RAM. Used in simulation and in small FPGA builds to stand in for the HPS DDR3 bridge, including the `0x30000000` address window check. The optional backpressure generator stresses the arbiter's `DDRAM_BUSY` handling.

---
 rtl/ddram_pkg.sv | 30 +++
 rtl/ddram_resp_mem.sv | 41 ++++
 rtl/ddram_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ddram_pkg.sv
// rtl/ddram_pkg.sv - shared types and constants for the DDRAM burst responder
//
// Purpose: FSM state encoding, address-window constant, error-flag bit
//          positions and the backpressure LFSR seed/step used by
//          ddram_responder.
// Ports:   none (package).

package ddram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RWAIT  = 2'd2,
    RDATA  = 2'd3
  } ddram_resp_state_t;

  // DDRAM_ADDR[28:25] must equal this for the command to hit the RAM
  localparam logic [3:0] DDRAM_WIN = 4'b0011;

  localparam int ERR_ADDR  = 0;
  localparam int ERR_PROTO = 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1, shifting right
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/ddram_resp_mem.sv
// rtl/ddram_resp_mem.sv - 64-bit simple dual-port RAM with byte enables
//
// Purpose: backing store for ddram_responder. One write port with per-byte
//          enables, one read port with a single registered output stage.
//          The read register only loads when re is high, so rdata holds
//          between reads. Contents are never cleared.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write word address
//   wdata  in   write data
//   be     in   byte enables for the write
//   re     in   read enable (loads rdata at the edge)
//   raddr  in   read word address
//   rdata  out  registered read data

module ddram_resp_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [63:0]       wdata,
  input  logic [7:0]        be,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [63:0]       rdata
);

  logic [63:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ddram_responder.sv
// rtl/ddram_responder.sv - memory-side responder for the 64-bit DDRAM burst port
//
// Purpose: answers DDRAM read/write bursts from on-chip RAM, checking the
//          0x30000000 window (DDRAM_ADDR[28:25] == 4'b0011). Sticky err
//          flags report out-of-window commands and protocol violations.
// Optional feature: define DDRAM_RESP_BACKPRESSURE_EN to add an LFSR that
//          randomly raises DDRAM_BUSY while idle or mid write burst.
// Ports:
//   DDRAM_CLK         in   clock
//   DDRAM_RESET_N     in   asynchronous active-low reset
//   DDRAM_BUSY        out  waitrequest
//   DDRAM_BURSTCNT    in   beats per command (0 is treated as 1)
//   DDRAM_ADDR        in   64-bit word address
//   DDRAM_RD          in   read command
//   DDRAM_WE          in   write command / write beat
//   DDRAM_DIN         in   write data
//   DDRAM_BE          in   write byte enables
//   DDRAM_DOUT        out  read data (holds when DOUT_READY is low)
//   DDRAM_DOUT_READY  out  read beat valid
//   err               out  sticky flags: [0] out of window, [1] protocol

module ddram_responder
  import ddram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic        DDRAM_CLK,
  input  logic        DDRAM_RESET_N,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  output logic [1:0]  err
);

  // RWAIT lasts RD_LATENCY-1 cycles; the RAM read goes out in its last one
  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 2);

  ddram_resp_state_t state, state_nxt;

  logic [ADDR_W-1:0] ptr_q, ptr_d;     // next word of the current burst
  logic [7:0]        left_q, left_d;   // writes: beats still due; reads: RAM reads still to issue
  logic [3:0]        lat_q, lat_d;
  logic              oob_q, oob_d;     // current burst is outside the window
  logic [1:0]        err_q, err_d;
  logic              dout_zero_q;      // last issued read was out of window (or none since reset)

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [63:0]       mem_rdata;

  logic              busy_fsm, bp_busy, busy;
  logic              acc_we, acc_rd, in_win;
  logic [7:0]        cnt_eff;
  logic [ADDR_W-1:0] cmd_idx;
  logic              unused_addr;

  assign unused_addr = ^DDRAM_ADDR;

  assign busy_fsm = (state == RWAIT) || (state == RDATA);

`ifdef DDRAM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
    if (!DDRAM_RESET_N) lfsr_q <= LFSR_SEED;
    else                lfsr_q <= lfsr_next(lfsr_q);
  end

  assign bp_busy = ((state == IDLE) || (state == WBURST)) && (lfsr_q[1:0] == 2'b00);
`else
  assign bp_busy = 1'b0;
`endif

  assign busy    = busy_fsm | bp_busy;
  assign acc_we  = DDRAM_WE & ~busy;
  assign acc_rd  = DDRAM_RD & ~busy;
  assign in_win  = (DDRAM_ADDR[28:25] == DDRAM_WIN);
  assign cnt_eff = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
  assign cmd_idx = DDRAM_ADDR[ADDR_W-1:0];

  always_comb begin
    state_nxt = state;
    ptr_d     = ptr_q;
    left_d    = left_q;
    lat_d     = lat_q;
    oob_d     = oob_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_re    = 1'b0;

    case (state)
      IDLE: begin
        if (acc_we) begin
          // beat 0 is written at the accepting edge
          mem_we    = in_win;
          mem_waddr = cmd_idx;
          ptr_d     = cmd_idx + ADDR_W'(1);
          left_d    = cnt_eff - 8'd1;
          oob_d     = ~in_win;
          if (!in_win) err_d[ERR_ADDR] = 1'b1;
          if ((DDRAM_BURSTCNT == 8'd0) || DDRAM_RD) err_d[ERR_PROTO] = 1'b1;
          if (cnt_eff > 8'd1) state_nxt = WBURST;
        end else if (acc_rd) begin
          ptr_d  = cmd_idx;
          left_d = cnt_eff;
          lat_d  = LAT_INIT;
          oob_d  = ~in_win;
          if (!in_win) err_d[ERR_ADDR] = 1'b1;
          if (DDRAM_BURSTCNT == 8'd0) err_d[ERR_PROTO] = 1'b1;
          state_nxt = RWAIT;
        end
      end

      WBURST: begin
        if (DDRAM_RD) err_d[ERR_PROTO] = 1'b1;
        if (acc_we) begin
          mem_we = ~oob_q;
          ptr_d  = ptr_q + ADDR_W'(1);
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) state_nxt = IDLE;
        end
      end

      RWAIT: begin
        if (lat_q == 4'd0) begin
          mem_re    = 1'b1;
          ptr_d     = ptr_q + ADDR_W'(1);
          left_d    = left_q - 8'd1;
          state_nxt = RDATA;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      RDATA: begin
        // keep the registered read one beat ahead of the presented beat
        if (left_q != 8'd0) begin
          mem_re = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
          left_d = left_q - 8'd1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
    if (!DDRAM_RESET_N) begin
      state       <= IDLE;
      ptr_q       <= '0;
      left_q      <= '0;
      lat_q       <= '0;
      oob_q       <= 1'b0;
      err_q       <= '0;
      dout_zero_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      ptr_q  <= ptr_d;
      left_q <= left_d;
      lat_q  <= lat_d;
      oob_q  <= oob_d;
      err_q  <= err_d;
      if (mem_re) dout_zero_q <= oob_q;
    end
  end

  ddram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (DDRAM_CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (DDRAM_DIN),
    .be    (DDRAM_BE),
    .re    (mem_re),
    .raddr (ptr_q),
    .rdata (mem_rdata)
  );

  // the RAM has no reset, so the output is forced to zero until a real read lands
  assign DDRAM_DOUT       = dout_zero_q ? 64'h0 : mem_rdata;
  assign DDRAM_DOUT_READY = (state == RDATA);
  assign DDRAM_BUSY       = busy;
  assign err              = err_q;

endmodule
